// File: rtl/fir_coef_loader.sv
// ---------------------------------------------------------------------------
// fir_coef_loader
//   Sequences a serial FIR filter. It owns the FIR's weight-configuration port
//   and gates the FIR's sample input.
//   - A host load request makes it read WINLEN coefficients from an external
//     table that has a 1-cycle read latency.
//   - It waits for the FIR to go idle, then writes the coefficients into the
//     FIR weight RAM.
//   - Source samples reach the FIR only while a complete coefficient set is
//     loaded and no load is in progress.
//
// Ports
//   clk, rst            clock; asynchronous active-high reset
//   load_req/load_busy  host load handshake; load_base is sampled on accept
//   load_done           1-cycle pulse when a load completes
//   coef_valid          a complete coefficient set is present in the FIR
//   tbl_rd_*            coefficient table read port (data one cycle later)
//   src_*               upstream sample stream (valid/busy/data)
//   fir_din_*           FIR sample input; fir_din_busy low means the FIR is idle
//   cfg_*               FIR weight RAM write port
//   sample_cnt          samples forwarded since the last load_done (wraps)
// ---------------------------------------------------------------------------
module fir_coef_loader #(
    parameter int DWIDTH = 8,
    parameter int AWIDTH = 6,
    parameter int WINLEN = 64,
    parameter int TWIDTH = 8,
    parameter int CWIDTH = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load_req,
    output logic              load_busy,
    input  logic [TWIDTH-1:0] load_base,
    output logic              load_done,
    output logic              coef_valid,
    output logic              tbl_rd_en,
    output logic [TWIDTH-1:0] tbl_rd_addr,
    input  logic [DWIDTH-1:0] tbl_rd_data,
    input  logic              src_valid,
    output logic              src_busy,
    input  logic [DWIDTH-1:0] src_data,
    output logic              fir_din_valid,
    input  logic              fir_din_busy,
    output logic [DWIDTH-1:0] fir_din_data,
    output logic              cfg_valid,
    output logic [AWIDTH-1:0] cfg_addr,
    output logic [DWIDTH-1:0] cfg_data,
    output logic [CWIDTH-1:0] sample_cnt
);

    typedef enum logic [2:0] {
        ST_EMPTY,   // no valid coefficient set, samples blocked
        ST_PASS,    // coefficients loaded, samples forwarded
        ST_WAIT,    // load accepted, waiting for the FIR to go idle
        ST_LOAD,    // issuing table reads
        ST_FIN      // last weight write in flight
    } state_t;

    localparam logic [AWIDTH-1:0] LAST_IDX = AWIDTH'(WINLEN - 1);

    state_t            st;
    logic [TWIDTH-1:0] base;
    logic [AWIDTH-1:0] cnt;
    logic              load_accept;
    logic              xfer;

    // Load requests are accepted only in EMPTY or PASS. load_busy is low in
    // exactly those states.
    assign load_accept = load_req && !load_busy;
    assign xfer        = src_valid && !src_busy;

    // The sample path is a combinational pass-through in PASS. Outside PASS
    // the source is stalled, so the FIR never sees a partial coefficient set.
    assign fir_din_valid = src_valid && (st == ST_PASS);
    assign src_busy      = (st != ST_PASS) || fir_din_busy;
    assign fir_din_data  = src_data;

    // Table data arrives one cycle after the read strobe. That is the same
    // cycle in which the registered cfg_valid/cfg_addr pair is presented, so
    // the data passes straight through.
    assign cfg_data = tbl_rd_data;

    // NOTE: every register below uses non-blocking assignments. Each branch
    // therefore sees the values from before the clock edge. The cfg pipeline
    // relies on this: it samples tbl_rd_en and cnt as they were during the read.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            st          <= ST_EMPTY;
            base        <= '0;
            cnt         <= '0;
            load_busy   <= 1'b0;
            load_done   <= 1'b0;
            coef_valid  <= 1'b0;
            tbl_rd_en   <= 1'b0;
            tbl_rd_addr <= '0;
            cfg_valid   <= 1'b0;
            cfg_addr    <= '0;
            sample_cnt  <= '0;
        end else begin
            // load_done defaults low, so setting it in FIN makes a 1-cycle pulse.
            load_done <= 1'b0;

            // Weight writes trail the table reads by exactly one cycle.
            cfg_valid <= tbl_rd_en;
            cfg_addr  <= cnt;

            if (xfer) begin
                sample_cnt <= sample_cnt + 1'b1;
            end

            case (st)
                ST_EMPTY, ST_PASS: begin
                    if (load_accept) begin
                        st         <= ST_WAIT;
                        base       <= load_base;
                        cnt        <= '0;
                        load_busy  <= 1'b1;
                        coef_valid <= 1'b0;
                    end
                end

                ST_WAIT: begin
                    // A sample forwarded in the accept cycle may still be in
                    // the FIR. Its weights must not change until it drains.
                    if (!fir_din_busy) begin
                        st          <= ST_LOAD;
                        tbl_rd_en   <= 1'b1;
                        tbl_rd_addr <= base;
                    end
                end

                ST_LOAD: begin
                    cnt         <= cnt + 1'b1;
                    tbl_rd_addr <= tbl_rd_addr + 1'b1;  // wraps modulo 2**TWIDTH
                    if (cnt == LAST_IDX) begin
                        st        <= ST_FIN;
                        tbl_rd_en <= 1'b0;
                    end
                end

                ST_FIN: begin
                    st         <= ST_PASS;
                    load_done  <= 1'b1;
                    load_busy  <= 1'b0;
                    coef_valid <= 1'b1;
                    sample_cnt <= '0;
                end

                default: begin
                    st <= ST_EMPTY;
                end
            endcase
        end
    end

endmodule
